// File: rtl/myproject_sdiv_30s_16s_seq.sv
// Sequential radix-2 restoring signed divider, 30s / 16s -> 30s quotient, 16s remainder.
// Optional MYPROJECT_SDIV_DBZ_FAST_EN: zero divisor skips the iteration phase.
module myproject_sdiv_30s_16s_seq #(
    parameter int DIVIDEND_WIDTH = 30,
    parameter int DIVISOR_WIDTH  = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      dbz,
    output logic                      ovf
);

    localparam int AW = DIVIDEND_WIDTH;
    localparam int BW = DIVISOR_WIDTH;
    localparam int CW = $clog2(AW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_sign_a;
    logic            r_sign_b;
    logic [AW:0]     r_mag_a;
    logic [BW:0]     r_mag_b;
    logic [BW:0]     r_part;
    logic [AW-1:0]   r_q;
    logic [BW-1:0]   r_a_lo;
    logic            r_is_dbz;
    logic            r_is_ovf;
    logic [AW-1:0]   r_quot;
    logic [BW-1:0]   r_rem;
    logic            r_dbz;
    logic            r_ovf;
    logic            r_out_valid;

    logic [AW:0]     w_ext_a;
    logic [AW:0]     w_abs_a;
    logic [BW:0]     w_ext_b;
    logic [BW:0]     w_abs_b;
    logic [BW+1:0]   w_shift;
    logic            w_ge;
    logic [BW:0]     w_sub;
    logic [AW-1:0]   w_q_neg;
    logic [BW-1:0]   w_r_neg;
    logic            w_accept;
    logic            w_b_zero;
    logic            w_ovf_case;

    assign w_ext_a = {dividend[AW-1], dividend};
    assign w_abs_a = dividend[AW-1] ? (~w_ext_a) + (AW+1)'(1) : w_ext_a;
    assign w_ext_b = {divisor[BW-1], divisor};
    assign w_abs_b = divisor[BW-1] ? (~w_ext_b) + (BW+1)'(1) : w_ext_b;

    assign w_b_zero   = (divisor == '0);
    assign w_ovf_case = (dividend == {1'b1, {(AW-1){1'b0}}}) && (divisor == '1);

    // One restoring step: shift in the next dividend magnitude bit, MSB first.
    assign w_shift = {r_part, r_mag_a[r_cnt]};
    assign w_ge    = w_shift >= {1'b0, r_mag_b};
    assign w_sub   = w_shift[BW:0] - r_mag_b;

    assign w_q_neg = (~r_q) + AW'(1);
    assign w_r_neg = (~r_part[BW-1:0]) + BW'(1);

    assign w_accept = in_valid && in_ready;

    assign in_ready  = (r_state == S_IDLE) && !ap_rst;
    assign out_valid = r_out_valid;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign dbz       = r_dbz;
    assign ovf       = r_ovf;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_part      <= '0;
            r_q         <= '0;
            r_a_lo      <= '0;
            r_is_dbz    <= 1'b0;
            r_is_ovf    <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign_a <= dividend[AW-1];
                        r_sign_b <= divisor[BW-1];
                        r_mag_a  <= w_abs_a;
                        r_mag_b  <= w_abs_b;
                        r_a_lo   <= dividend[BW-1:0];
                        r_is_dbz <= w_b_zero;
                        r_is_ovf <= w_ovf_case;
                        r_part   <= '0;
                        r_q      <= '0;
                        r_cnt    <= CW'(AW-1);
`ifdef MYPROJECT_SDIV_DBZ_FAST_EN
                        r_state  <= w_b_zero ? S_FIX : S_CALC;
`else
                        r_state  <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    r_part <= w_ge ? w_sub : w_shift[BW:0];
                    r_q    <= {r_q[AW-2:0], w_ge};
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_dbz) begin
                        r_quot <= '1;
                        r_rem  <= r_a_lo;
                        r_dbz  <= 1'b1;
                        r_ovf  <= 1'b0;
                    end else begin
                        r_quot <= (r_sign_a ^ r_sign_b) ? w_q_neg : r_q;
                        r_rem  <= r_sign_a ? w_r_neg : r_part[BW-1:0];
                        r_dbz  <= 1'b0;
                        r_ovf  <= r_is_ovf;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
